// File: rtl/ex_res_driver.sv
// rtl/ex_res_driver.sv - Ex/Mem2 result driver into a one-hot OR-combined slot array
// Mem2 wins, then the holding buffer head, then direct Ex; losing Ex results are queued.
module ex_res_driver #(
  parameter int INPUTNUM = 7,
  parameter int BITWIDTH = 32,
  parameter int MEM2SLOT = 5,
  parameter int BUFDEPTH = 2,
  localparam int SlotW = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               iExVld,
  input  logic [SlotW-1:0]                   iExSlot,
  input  logic [BITWIDTH-1:0]                iExRes,
  input  logic                               iMem2Vld,
  input  logic [BITWIDTH-1:0]                iMem2Res,
  input  logic                               iFlush,
  output logic [INPUTNUM-1:0][BITWIDTH-1:0]  oExResult,
  output logic                               oResVld,
  output logic [SlotW-1:0]                   oResSlot,
  output logic                               oExStall,
  output logic                               oErr
);

  localparam int PtrW = $clog2(BUFDEPTH);
  localparam int CntW = $clog2(BUFDEPTH + 1);
  localparam logic [SlotW:0]   SlotLimit = (SlotW + 1)'(INPUTNUM);
  localparam logic [SlotW-1:0] Mem2Idx   = SlotW'(MEM2SLOT);
  localparam logic [CntW-1:0]  Depth     = CntW'(BUFDEPTH);

  logic [BITWIDTH-1:0] bufData [BUFDEPTH];
  logic [SlotW-1:0]    bufSlot [BUFDEPTH];
  logic [PtrW-1:0]     rdPtr, wrPtr;
  logic [CntW-1:0]     count;

  logic exIllegal, exLegal, selMem2, selHead, selEx, exPend, push, pop, dropFull, errSet;

  always_comb begin
    exIllegal = iExVld && ((iExSlot == Mem2Idx) || ({1'b0, iExSlot} >= SlotLimit));
    exLegal   = iExVld && !exIllegal;
    selMem2   = iMem2Vld;
    // A flush kills the buffer, so its head must not be forwarded that cycle.
    selHead   = !iMem2Vld && !iFlush && (count != '0);
    selEx     = !iMem2Vld && !iFlush && (count == '0) && exLegal;
    pop       = selHead;
    exPend    = exLegal && !iFlush && !selEx;
    push      = exPend && ((count != Depth) || pop);
    dropFull  = exPend && (count == Depth) && !pop;
    errSet    = (iExVld && !iFlush && exIllegal) || dropFull;
  end

  assign oExStall = (count >= Depth - CntW'(1));

  always_ff @(posedge clk) begin
    if (push) begin
      bufData[wrPtr] <= iExRes;
      bufSlot[wrPtr] <= iExSlot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oExResult <= '0;
      oResVld   <= 1'b0;
      oResSlot  <= '0;
      oErr      <= 1'b0;
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      oExResult <= '0;
      oResVld   <= 1'b0;
      oResSlot  <= '0;
      if (selMem2) begin
        oExResult[Mem2Idx] <= iMem2Res;
        oResVld            <= 1'b1;
        oResSlot           <= Mem2Idx;
      end else if (selHead) begin
        oExResult[bufSlot[rdPtr]] <= bufData[rdPtr];
        oResVld                   <= 1'b1;
        oResSlot                  <= bufSlot[rdPtr];
      end else if (selEx) begin
        oExResult[iExSlot] <= iExRes;
        oResVld            <= 1'b1;
        oResSlot           <= iExSlot;
      end
      if (errSet) oErr <= 1'b1;
      if (iFlush) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        count <= count + CntW'(push) - CntW'(pop);
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_res_driver.sv
// tb/tb_ex_res_driver.sv - directed self-checking bench for ex_res_driver
module tb_ex_res_driver;
  localparam int N = 7;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              iExVld = 1'b0;
  logic [2:0]        iExSlot = '0;
  logic [W-1:0]      iExRes = '0;
  logic              iMem2Vld = 1'b0;
  logic [W-1:0]      iMem2Res = '0;
  logic              iFlush = 1'b0;
  logic [N-1:0][W-1:0] oExResult;
  logic              oResVld;
  logic [2:0]        oResSlot;
  logic              oExStall;
  logic              oErr;

  int checks = 0;
  int errors = 0;

  ex_res_driver dut (
    .clk(clk), .rst(rst), .iExVld(iExVld), .iExSlot(iExSlot), .iExRes(iExRes),
    .iMem2Vld(iMem2Vld), .iMem2Res(iMem2Res), .iFlush(iFlush),
    .oExResult(oExResult), .oResVld(oResVld), .oResSlot(oResSlot),
    .oExStall(oExStall), .oErr(oErr)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] mk(input int slot, input logic [W-1:0] d);
    logic [N*W-1:0] v;
    v = '0;
    v[slot*W +: W] = d;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [2:0] s, input logic [W-1:0] d);
    iExVld = v; iExSlot = s; iExRes = d;
  endtask

  task automatic mem2(input logic v, input logic [W-1:0] d);
    iMem2Vld = v; iMem2Res = d;
  endtask

  task automatic idle();
    ex(1'b0, 3'd0, '0); mem2(1'b0, '0); iFlush = 1'b0;
  endtask

  task automatic expOut(input string tag, input logic v, input int slot, input logic [W-1:0] d);
    chk({tag, "_res"}, oExResult, v ? mk(slot, d) : '0);
    chk({tag, "_vld"}, oResVld, v);
    chk({tag, "_slot"}, oResSlot, v ? slot : 0);
  endtask

  task automatic doReset();
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    expOut("reset", 1'b0, 0, '0);
    chk("reset_err", oErr, 1'b0);
    chk("reset_stall", oExStall, 1'b0);
    rst = 1'b0;

    // Ex bypass
    ex(1'b1, 3'd2, 32'h1234);
    step();
    expOut("bypass", 1'b1, 2, 32'h1234);
    chk("bypass_stall", oExStall, 1'b0);
    idle();
    step();
    expOut("bypass_idle", 1'b0, 0, '0);

    // collision, then push+pop in the same cycle
    ex(1'b1, 3'd0, 32'hA); mem2(1'b1, 32'hB);
    step();
    expOut("coll_mem2", 1'b1, 5, 32'hB);
    chk("coll_stall", oExStall, 1'b1);
    ex(1'b1, 3'd1, 32'hC); mem2(1'b0, '0);
    step();
    expOut("coll_head", 1'b1, 0, 32'hA);
    chk("pushpop_stall", oExStall, 1'b1);
    idle();
    step();
    expOut("pushpop_head", 1'b1, 1, 32'hC);
    chk("pushpop_drain_stall", oExStall, 1'b0);
    chk("coll_err", oErr, 1'b0);

    // overflow
    ex(1'b1, 3'd1, 32'h11); mem2(1'b1, 32'h100);
    step();
    expOut("ovf_m0", 1'b1, 5, 32'h100);
    ex(1'b1, 3'd3, 32'h33); mem2(1'b1, 32'h101);
    step();
    expOut("ovf_m1", 1'b1, 5, 32'h101);
    chk("ovf_err_pre", oErr, 1'b0);
    ex(1'b1, 3'd4, 32'h44); mem2(1'b1, 32'h102);
    step();
    expOut("ovf_m2", 1'b1, 5, 32'h102);
    chk("ovf_err", oErr, 1'b1);
    chk("ovf_stall", oExStall, 1'b1);
    idle();
    step();
    expOut("ovf_h0", 1'b1, 1, 32'h11);
    step();
    expOut("ovf_h1", 1'b1, 3, 32'h33);
    step();
    expOut("ovf_empty", 1'b0, 0, '0);
    chk("ovf_err_sticky", oErr, 1'b1);
    doReset();
    chk("err_cleared", oErr, 1'b0);

    // flush with one buffered entry and a simultaneous Mem2
    ex(1'b1, 3'd0, 32'h77); mem2(1'b1, 32'h60);
    step();
    expOut("fl_m0", 1'b1, 5, 32'h60);
    ex(1'b1, 3'd1, 32'h99); mem2(1'b1, 32'h55); iFlush = 1'b1;
    step();
    expOut("flush", 1'b1, 5, 32'h55);
    chk("flush_stall", oExStall, 1'b0);
    idle();
    step();
    expOut("flush_after", 1'b0, 0, '0);
    chk("flush_err", oErr, 1'b0);

    // illegal slots
    ex(1'b1, 3'd5, 32'hDEAD);
    step();
    expOut("ill5", 1'b0, 0, '0);
    chk("ill5_err", oErr, 1'b1);
    idle();
    doReset();
    ex(1'b1, 3'd7, 32'hBEEF);
    step();
    expOut("ill7", 1'b0, 0, '0);
    chk("ill7_err", oErr, 1'b1);
    idle();
    doReset();

    // async reset mid-burst
    ex(1'b1, 3'd2, 32'h1); mem2(1'b1, 32'h5);
    step();
    ex(1'b1, 3'd3, 32'h3); mem2(1'b1, 32'h6);
    step();
    expOut("ar_pre", 1'b1, 5, 32'h6);
    chk("ar_pre_stall", oExStall, 1'b1);
    idle();
    #2 rst = 1'b1;
    #1;
    expOut("ar_imm", 1'b0, 0, '0);
    chk("ar_imm_stall", oExStall, 1'b0);
    step();
    rst = 1'b0;
    ex(1'b1, 3'd6, 32'h66);
    step();
    expOut("ar_new", 1'b1, 6, 32'h66);
    idle();
    step();
    expOut("ar_nostale", 1'b0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
